// File: rtl/vram_arbiter_if.sv
// Bundle between the text renderer, MCU write link and the character RAM.
// The arbiter takes the slave view; the side driving requests and holding the RAM takes master.
interface vram_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          frame;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clr_req;
  logic          clr_busy;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  frame, disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_req, ram_rdata,
    output disp_valid, disp_data, wr_ready, clr_busy, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output frame, disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_req, ram_rdata,
    input  disp_valid, disp_data, wr_ready, clr_busy, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port character RAM arbiter: scanout reads win every slot, MCU writes queue in a
// small FIFO, and a frame-aligned clear sweeps the screen before queued writes resume.
module vram_arbiter #(
  parameter int            AW      = 11,
  parameter int            DW      = 8,
  parameter int            DEPTH   = 2000,
  parameter int            FIFO_AW = 2,
  parameter logic [DW-1:0] CLR_VAL = DW'(8'h20)
) (
  input logic           pix_clk,
  input logic           rst_n,
  vram_arbiter_if.slave bus
);

  localparam int FIFO_N = 1 << FIFO_AW;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLR_WAIT = 2'd1;
  localparam logic [1:0] ST_CLEAR    = 2'd2;

  logic [1:0]         state;
  logic [AW-1:0]      clr_ptr;
  logic [AW-1:0]      fifo_addr [FIFO_N];
  logic [DW-1:0]      fifo_data [FIFO_N];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               disp_grant;
  logic               clr_grant;
  logic               vld_p0;
  logic               vld_p1;

  assign full         = (count == (FIFO_AW+1)'(FIFO_N));
  assign empty        = (count == '0);
  assign bus.wr_ready = !full;
  assign bus.clr_busy = (state != ST_IDLE);
  assign push         = bus.wr_valid && !full;

  // Scanout never waits; the clear sweep holds off the FIFO so queued text lands on top of it.
  assign disp_grant = bus.disp_req;
  assign clr_grant  = !bus.disp_req && (state == ST_CLEAR);
  assign pop        = !bus.disp_req && (state != ST_CLEAR) && !empty;

  always_ff @(posedge pix_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr;
      fifo_data[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.clr_req) state <= ST_CLR_WAIT;
        ST_CLR_WAIT: begin
          clr_ptr <= '0;
          if (bus.frame) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clr_grant) begin
            if (clr_ptr == AW'(DEPTH-1)) begin
              clr_ptr <= '0;
              state   <= ST_IDLE;
            end else begin
              clr_ptr <= clr_ptr + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: granted command presented to the RAM
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      vld_p0        <= 1'b0;
    end else begin
      bus.ram_en    <= disp_grant || clr_grant || pop;
      bus.ram_we    <= clr_grant || pop;
      bus.ram_addr  <= disp_grant ? bus.disp_addr :
                       clr_grant  ? clr_ptr : fifo_addr[rd_ptr];
      bus.ram_wdata <= clr_grant ? CLR_VAL : fifo_data[rd_ptr];
      vld_p0        <= disp_grant;
    end
  end

  // Stage p1: RAM read data on ram_rdata; stage p2: registered scanout result
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1         <= 1'b0;
      bus.disp_valid <= 1'b0;
      bus.disp_data  <= '0;
    end else begin
      vld_p1         <= vld_p0;
      bus.disp_valid <= vld_p1;
      if (vld_p1) bus.disp_data <= bus.ram_rdata;
    end
  end

endmodule
